// File: rtl/job_ctrl_pkg.sv
// Shared types for the job tracker: slot state encoding and its width.
// Optional feature macro: JOB_CTRL_SUSPEND_EN (adds the SUSPENDED state and
// widens each slot's state to 3 bits).
package job_ctrl_pkg;

`ifdef JOB_CTRL_SUSPEND_EN
    localparam int ST_W = 3;
`else
    localparam int ST_W = 2;
`endif

    typedef enum logic [ST_W-1:0] {
        ST_IDLE      = ST_W'(0),
        ST_RUNNING   = ST_W'(1),
        ST_FINISHED  = ST_W'(2),
        ST_KILLED    = ST_W'(3)
`ifdef JOB_CTRL_SUSPEND_EN
        ,ST_SUSPENDED = ST_W'(4)
`endif
    } job_state_e;

    // A slot is "live" while an await on it must keep waiting.
    function automatic logic is_live(job_state_e s);
`ifdef JOB_CTRL_SUSPEND_EN
        return (s == ST_RUNNING) || (s == ST_SUSPENDED);
`else
        return (s == ST_RUNNING);
`endif
    endfunction

endpackage

// File: rtl/job_slot.sv
// One job slot: lifecycle FSM plus countdown counter.
// Optional feature macro: JOB_CTRL_SUSPEND_EN (suspend/resume strobes).
module job_slot
    import job_ctrl_pkg::*;
#(
    parameter int DUR_W = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_spawn,
    input  logic             i_kill,
    input  logic             i_reap,
`ifdef JOB_CTRL_SUSPEND_EN
    input  logic             i_suspend,
    input  logic             i_resume,
`endif
    input  logic [DUR_W-1:0] i_dur,
    output logic [ST_W-1:0]  o_state
);

    job_state_e       r_state;
    job_state_e       w_state_nxt;
    logic [DUR_W-1:0] r_cnt;
    logic [DUR_W-1:0] w_cnt_nxt;

    // State and counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking so every slot and the await logic act on the same pre-edge state.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter decode; a kill beats a natural finish on the same edge.
    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned (no latch).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_spawn) begin
                    w_state_nxt = ST_RUNNING;
                    w_cnt_nxt   = (i_dur == '0) ? DUR_W'(1) : i_dur;
                end
            end
            ST_RUNNING: begin
                if (i_kill)
                    w_state_nxt = ST_KILLED;
`ifdef JOB_CTRL_SUSPEND_EN
                else if (i_suspend)
                    w_state_nxt = ST_SUSPENDED;
`endif
                else if (r_cnt == DUR_W'(1)) begin
                    w_state_nxt = ST_FINISHED;
                    w_cnt_nxt   = '0;
                end else
                    w_cnt_nxt = r_cnt - DUR_W'(1);
            end
            ST_FINISHED, ST_KILLED: begin
                if (i_reap)
                    w_state_nxt = ST_IDLE;
            end
`ifdef JOB_CTRL_SUSPEND_EN
            ST_SUSPENDED: begin
                if (i_kill)
                    w_state_nxt = ST_KILLED;
                else if (i_resume)
                    w_state_nxt = ST_RUNNING;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/job_ctrl.sv
// Job tracker top: NUM_JOBS countdown slots with spawn allocation,
// kill/kill-all, reap, a single outstanding await and a running-job count.
// Optional feature macro: JOB_CTRL_SUSPEND_EN (suspend/resume ports).
module job_ctrl
    import job_ctrl_pkg::*;
#(
    parameter  int NUM_JOBS = 8,
    parameter  int DUR_W    = 8,
    localparam int ID_W     = $clog2(NUM_JOBS)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spawn_valid,
    input  logic [DUR_W-1:0]         spawn_dur,
    output logic                     spawn_ready,
    output logic [ID_W-1:0]          spawn_id,
    input  logic                     kill_valid,
    input  logic [ID_W-1:0]          kill_id,
    input  logic                     kill_all,
    input  logic                     reap_valid,
    input  logic [ID_W-1:0]          reap_id,
`ifdef JOB_CTRL_SUSPEND_EN
    input  logic                     suspend_valid,
    input  logic [ID_W-1:0]          suspend_id,
    input  logic                     resume_valid,
    input  logic [ID_W-1:0]          resume_id,
`endif
    input  logic                     await_valid,
    input  logic [ID_W-1:0]          await_id,
    output logic                     await_ready,
    output logic                     await_done,
    output logic [ST_W-1:0]          await_status,
    output logic [ST_W*NUM_JOBS-1:0] status,
    output logic [ID_W:0]            active_cnt
);

    job_state_e      w_state [NUM_JOBS];
    logic            w_any_idle;
    logic [ID_W-1:0] w_free_id;
    logic            w_spawn_fire;
    logic            w_await_acc;
    logic [ID_W-1:0] w_await_tgt;
    job_state_e      w_tgt_state;

    logic            r_await_busy;
    logic [ID_W-1:0] r_await_id;
    logic            r_await_done;
    job_state_e      r_await_status;

    assign w_spawn_fire = spawn_valid && w_any_idle;

    for (genvar g = 0; g < NUM_JOBS; g++) begin : g_slot
        logic [ST_W-1:0] w_slot_state;

        job_slot #(.DUR_W(DUR_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_spawn   (w_spawn_fire && (w_free_id == ID_W'(g))),
            .i_kill    (kill_all || (kill_valid && (kill_id == ID_W'(g)))),
            .i_reap    (reap_valid && (reap_id == ID_W'(g))),
`ifdef JOB_CTRL_SUSPEND_EN
            .i_suspend (suspend_valid && (suspend_id == ID_W'(g))),
            .i_resume  (resume_valid && (resume_id == ID_W'(g))),
`endif
            .i_dur     (spawn_dur),
            .o_state   (w_slot_state)
        );

        assign w_state[g]              = job_state_e'(w_slot_state);
        assign status[g*ST_W +: ST_W]  = w_slot_state;
    end

    // Lowest-index IDLE slot from pre-edge state, so a slot reaped this edge is not offered.
    always_comb begin
        w_any_idle = 1'b0;
        w_free_id  = '0;
        for (int i = NUM_JOBS - 1; i >= 0; i--) begin
            if (w_state[i] == ST_IDLE) begin
                w_any_idle = 1'b1;
                w_free_id  = ID_W'(i);
            end
        end
    end

    // Popcount of RUNNING slots.
    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < NUM_JOBS; i++) begin
            if (w_state[i] == ST_RUNNING)
                active_cnt = active_cnt + (ID_W + 1)'(1);
        end
    end

    assign w_await_acc = await_valid && !r_await_busy;
    assign w_await_tgt = w_await_acc ? await_id : r_await_id;
    assign w_tgt_state = w_state[w_await_tgt];

    // Await tracker: completes on the first edge that sees the target not live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_await_busy   <= 1'b0;
            r_await_id     <= '0;
            r_await_done   <= 1'b0;
            r_await_status <= ST_IDLE;
        end else begin
            r_await_done <= 1'b0;
            if (w_await_acc || r_await_busy) begin
                if (is_live(w_tgt_state)) begin
                    r_await_busy <= 1'b1;
                    r_await_id   <= w_await_tgt;
                end else begin
                    r_await_busy   <= 1'b0;
                    r_await_done   <= 1'b1;
                    r_await_status <= w_tgt_state;
                end
            end
        end
    end

    assign spawn_ready  = w_any_idle;
    assign spawn_id     = w_free_id;
    assign await_ready  = !r_await_busy;
    assign await_done   = r_await_done;
    assign await_status = r_await_status;

endmodule
